// File: rtl/head_pkg.sv
// Shared widths, FSM encoding and done-record type for the header-buffer write front end.
package head_pkg;
  localparam int DATA_W    = 32;
  localparam int ID_W      = 5;
  localparam int NUM_IDS   = 32;
  localparam int MAX_WORDS = 32;
  localparam int LEN_W     = 6;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HEAD  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
    logic             err;
  } done_t;

  // Index of the lowest set bit; 0 when none are set.
  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_IDS-1:0] vec);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = ID_W'(i);
      end
    end
    return idx;
  endfunction
endpackage

// File: rtl/id_pool.sv
// Free-slot bitmap: hands out the lowest free ramID and takes slots back from the parser.
module id_pool
  import head_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc,
  input  logic             release_valid,
  input  logic [ID_W-1:0]  release_id,
  output logic [ID_W-1:0]  alloc_id,
  output logic [CNT_W-1:0] free_cnt,
  output logic             empty
);
  logic [NUM_IDS-1:0] free_r;
  logic [NUM_IDS-1:0] alloc_mask_s;
  logic [NUM_IDS-1:0] rel_mask_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               rel_ok_s;

  assign alloc_id = lowest_set(free_r);
  assign free_cnt = cnt_r;
  assign empty    = (cnt_r == '0);

  // Returning a slot that is already free is ignored, so it cannot inflate the count.
  always_comb begin
    rel_ok_s     = release_valid & ~free_r[release_id];
    alloc_mask_s = {{(NUM_IDS-1){1'b0}}, alloc} << alloc_id;
    rel_mask_s   = {{(NUM_IDS-1){1'b0}}, rel_ok_s} << release_id;
  end

  // Bitmap and population count update together; alloc and release may coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      free_r <= '1;
      cnt_r  <= CNT_W'(NUM_IDS);
    end else begin
      free_r <= (free_r & ~alloc_mask_s) | rel_mask_s;
      cnt_r  <= cnt_r + CNT_W'(rel_ok_s) - CNT_W'(alloc);
    end
  end
endmodule

// File: rtl/head_dispatcher.sv
// Streams the first MAX_WORDS words of each packet into a claimed header-buffer slot
// and reports completion to the parse engine.
module head_dispatcher
  import head_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pkt_in,
  input  logic              pkt_in_valid,
  input  logic              pkt_in_sop,
  input  logic              pkt_in_eop,
  output logic              pkt_in_ready,
  input  logic              release_valid,
  input  logic [ID_W-1:0]   release_ramID,
  output logic [DATA_W-1:0] head_out,
  output logic              head_out_valid,
  output logic [ID_W-1:0]   ramID_out,
  output logic              head_done_valid,
  output logic [ID_W-1:0]   head_done_ramID,
  output logic [LEN_W-1:0]  head_done_len,
  output logic              head_done_err,
  output logic [CNT_W-1:0]  free_cnt
);
  state_t             state_r, state_next_s;
  logic               accept_s, wr_s, alloc_s, last_s, trunc_s, empty_s;
  logic [LEN_W-1:0]   len_r, len_next_s;
  logic [ID_W-1:0]    ramid_r, alloc_id_s;
  logic [DATA_W-1:0]  head_r;
  logic               head_valid_r;
  done_t              stage_a_r, stage_b_r, done_r;

  id_pool u_pool (
    .clk           (clk),
    .reset         (reset),
    .alloc         (alloc_s),
    .release_valid (release_valid),
    .release_id    (release_ramID),
    .alloc_id      (alloc_id_s),
    .free_cnt      (free_cnt),
    .empty         (empty_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state, ready, and per-word write/alloc/close decisions.
  always_comb begin
    state_next_s = state_r;
    pkt_in_ready = 1'b0;
    wr_s         = 1'b0;
    alloc_s      = 1'b0;
    last_s       = 1'b0;
    trunc_s      = 1'b0;
    len_next_s   = len_r;
    case (state_r)
      IDLE:    pkt_in_ready = ~empty_s;
      HEAD:    pkt_in_ready = 1'b1;
      DRAIN:   pkt_in_ready = 1'b1;
      GAP:     pkt_in_ready = 1'b0;
      default: pkt_in_ready = 1'b0;
    endcase
    accept_s = pkt_in_valid & pkt_in_ready;
    case (state_r)
      IDLE: begin
        if (accept_s && pkt_in_sop) begin
          alloc_s      = 1'b1;
          wr_s         = 1'b1;
          len_next_s   = LEN_W'(1);
          last_s       = pkt_in_eop;
          state_next_s = pkt_in_eop ? GAP : HEAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      HEAD: begin
        if (accept_s && pkt_in_sop) begin
          // Missing eop: close the open burst with an error and discard the new packet.
          trunc_s      = 1'b1;
          state_next_s = pkt_in_eop ? GAP : DRAIN;
        end else if (accept_s) begin
          wr_s       = 1'b1;
          len_next_s = len_r + LEN_W'(1);
          if (pkt_in_eop) begin
            last_s       = 1'b1;
            state_next_s = GAP;
          end else if (len_next_s == LEN_W'(MAX_WORDS)) begin
            last_s       = 1'b1;
            state_next_s = DRAIN;
          end else begin
            state_next_s = HEAD;
          end
        end else begin
          state_next_s = HEAD;
        end
      end
      DRAIN: begin
        if (accept_s && pkt_in_eop) begin
          state_next_s = GAP;
        end else begin
          state_next_s = DRAIN;
        end
      end
      GAP:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Write port register and the three-stage done pipeline that trails the last write.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r       <= '0;
      head_valid_r <= 1'b0;
      ramid_r      <= '0;
      len_r        <= '0;
      stage_a_r    <= '0;
      stage_b_r    <= '0;
      done_r       <= '0;
    end else begin
      head_valid_r <= wr_s;
      if (wr_s) begin
        head_r <= pkt_in;
      end
      if (alloc_s) begin
        ramid_r <= alloc_id_s;
      end
      len_r <= len_next_s;
      stage_a_r.valid <= last_s;
      stage_a_r.id    <= last_s ? (alloc_s ? alloc_id_s : ramid_r) : '0;
      stage_a_r.len   <= last_s ? len_next_s : '0;
      stage_a_r.err   <= 1'b0;
      if (stage_a_r.valid) begin
        stage_b_r <= stage_a_r;
      end else if (trunc_s) begin
        stage_b_r <= '{valid: 1'b1, id: ramid_r, len: len_r, err: 1'b1};
      end else begin
        stage_b_r <= '0;
      end
      done_r <= stage_b_r;
    end
  end

  assign head_out        = head_r;
  assign head_out_valid  = head_valid_r;
  assign ramID_out       = ramid_r;
  assign head_done_valid = done_r.valid;
  assign head_done_ramID = done_r.id;
  assign head_done_len   = done_r.len;
  assign head_done_err   = done_r.err;
endmodule

// File: tb/tb_head_dispatcher.sv
// Scoreboard bench for head_dispatcher: directed packets push expectations, a monitor checks outputs.
module tb_head_dispatcher;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pkt_in;
  logic        pkt_in_valid, pkt_in_sop, pkt_in_eop, pkt_in_ready;
  logic        release_valid;
  logic [4:0]  release_ramID;
  logic [31:0] head_out;
  logic        head_out_valid;
  logic [4:0]  ramID_out;
  logic        head_done_valid;
  logic [4:0]  head_done_ramID;
  logic [5:0]  head_done_len;
  logic        head_done_err;
  logic [5:0]  free_cnt;

  head_dispatcher dut (
    .clk(clk), .reset(reset),
    .pkt_in(pkt_in), .pkt_in_valid(pkt_in_valid), .pkt_in_sop(pkt_in_sop),
    .pkt_in_eop(pkt_in_eop), .pkt_in_ready(pkt_in_ready),
    .release_valid(release_valid), .release_ramID(release_ramID),
    .head_out(head_out), .head_out_valid(head_out_valid), .ramID_out(ramID_out),
    .head_done_valid(head_done_valid), .head_done_ramID(head_done_ramID),
    .head_done_len(head_done_len), .head_done_err(head_done_err),
    .free_cnt(free_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [4:0] id; } hexp_t;
  typedef struct { logic [4:0] id; logic [5:0] len; logic err; } dexp_t;
  hexp_t exp_head[$];
  dexp_t exp_done[$];
  hexp_t he;
  dexp_t de;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_hov = -100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_head(input logic [31:0] d, input logic [4:0] id);
    exp_head.push_back('{d: d, id: id});
  endtask

  task automatic push_done(input logic [4:0] id, input logic [5:0] len, input logic err);
    exp_done.push_back('{id: id, len: len, err: err});
  endtask

  task automatic send(input logic [31:0] d, input logic s, input logic e);
    pkt_in = d; pkt_in_sop = s; pkt_in_eop = e; pkt_in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    pkt_in_valid = 1'b0; pkt_in_sop = 1'b0; pkt_in_eop = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rel(input logic [4:0] id);
    release_valid = 1'b1; release_ramID = id;
    @(posedge clk); #1;
    release_valid = 1'b0;
  endtask

  // Monitor: done is examined before head so back-to-back bursts measure against the earlier write.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (head_done_valid) begin
        if (exp_done.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL done_unexpected: got id %0d len %0d expected none", head_done_ramID, head_done_len);
        end else begin
          de = exp_done.pop_front();
          check("done_ramID", head_done_ramID, de.id);
          check("done_len", head_done_len, de.len);
          check("done_err", head_done_err, de.err);
          check("done_delay", cyc - last_hov, 2);
        end
      end
      if (head_out_valid) begin
        if (exp_head.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL head_unexpected: got %0h expected none", head_out);
        end else begin
          he = exp_head.pop_front();
          check("head_data", head_out, he.d);
          check("head_ramID", ramID_out, he.id);
        end
        last_hov = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pkt_in = 32'd0; pkt_in_valid = 1'b0; pkt_in_sop = 1'b0; pkt_in_eop = 1'b0;
    release_valid = 1'b0; release_ramID = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", pkt_in_ready, 1);
    check("rst_free", free_cnt, 32);
    check("rst_hov", head_out_valid, 0);
    check("rst_head", head_out, 0);
    check("rst_ramID", ramID_out, 0);
    check("rst_done", head_done_valid, 0);
    reset = 1'b0;

    // 3-word packet into slot 0
    push_head(32'hA000_000A, 5'd0); push_head(32'hB000_000B, 5'd0); push_head(32'hC000_000C, 5'd0);
    push_done(5'd0, 6'd3, 1'b0);
    send(32'hA000_000A, 1'b1, 1'b0); send(32'hB000_000B, 1'b0, 1'b0); send(32'hC000_000C, 1'b0, 1'b1);
    idle(5);
    check("t1_free", free_cnt, 31);
    rel(5'd0);
    check("t1_rel_free", free_cnt, 32);

    // 40-word packet: 32 stored, rest drained; next SOP held off by GAP
    for (int i = 0; i < 32; i++) push_head(32'h4000_0000 + i, 5'd0);
    push_done(5'd0, 6'd32, 1'b0);
    for (int i = 0; i < 40; i++) send(32'h4000_0000 + i, i == 0, i == 39);
    check("t2_gap_ready", pkt_in_ready, 0);
    push_head(32'hD000_000D, 5'd1); push_done(5'd1, 6'd1, 1'b0);
    pkt_in = 32'hD000_000D; pkt_in_sop = 1'b1; pkt_in_eop = 1'b1; pkt_in_valid = 1'b1;
    @(posedge clk); #1;
    check("t2_idle_ready", pkt_in_ready, 1);
    @(posedge clk); #1;
    idle(5);
    rel(5'd0); rel(5'd1);
    check("t2_free", free_cnt, 32);

    // Exhaustion with single-word packets
    for (int i = 0; i < 32; i++) begin
      push_head(32'h5000_0000 + i, 5'(i)); push_done(5'(i), 6'd1, 1'b0);
      send(32'h5000_0000 + i, 1'b1, 1'b1);
      idle(1);
    end
    idle(4);
    check("t3_free_zero", free_cnt, 0);
    push_head(32'h7777_0007, 5'd7); push_done(5'd7, 6'd1, 1'b0);
    pkt_in = 32'h7777_0007; pkt_in_sop = 1'b1; pkt_in_eop = 1'b1; pkt_in_valid = 1'b1;
    #1;
    check("t3_ready_empty", pkt_in_ready, 0);
    release_valid = 1'b1; release_ramID = 5'd7;
    @(posedge clk); #1;
    release_valid = 1'b0;
    check("t3_ready_after_rel", pkt_in_ready, 1);
    check("t3_free_after_rel", free_cnt, 1);
    @(posedge clk); #1;
    idle(4);
    check("t3_free_realloc", free_cnt, 0);

    // Simultaneous release and allocation; release of a free slot
    rel(5'd5);
    check("t4_free_one", free_cnt, 1);
    push_head(32'h5555_0005, 5'd5); push_done(5'd5, 6'd1, 1'b0);
    pkt_in = 32'h5555_0005; pkt_in_sop = 1'b1; pkt_in_eop = 1'b1; pkt_in_valid = 1'b1;
    release_valid = 1'b1; release_ramID = 5'd3;
    @(posedge clk); #1;
    release_valid = 1'b0;
    idle(4);
    check("t4_simul_free", free_cnt, 1);
    rel(5'd3);
    check("t4_rel_free_slot", free_cnt, 1);
    for (int i = 0; i < 32; i++) rel(5'(i));
    check("t4_all_free", free_cnt, 32);

    // SOP after 5 words: truncated done, new packet dropped
    for (int i = 0; i < 5; i++) push_head(32'h6000_0000 + i, 5'd0);
    push_done(5'd0, 6'd5, 1'b1);
    for (int i = 0; i < 5; i++) send(32'h6000_0000 + i, i == 0, 1'b0);
    send(32'h6100_0000, 1'b1, 1'b0); send(32'h6100_0001, 1'b0, 1'b0); send(32'h6100_0002, 1'b0, 1'b1);
    idle(5);
    check("t5_free", free_cnt, 31);
    rel(5'd0);
    check("t5_rel_free", free_cnt, 32);

    // Reset in the middle of HEAD
    push_head(32'h8000_0000, 5'd0); push_head(32'h8000_0001, 5'd0); push_head(32'h8000_0002, 5'd0);
    send(32'h8000_0000, 1'b1, 1'b0); send(32'h8000_0001, 1'b0, 1'b0); send(32'h8000_0002, 1'b0, 1'b0);
    pkt_in_valid = 1'b0; pkt_in_sop = 1'b0; pkt_in_eop = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_hov", head_out_valid, 0);
    check("t6_head", head_out, 0);
    check("t6_ramID", ramID_out, 0);
    check("t6_free", free_cnt, 32);
    check("t6_ready", pkt_in_ready, 1);
    check("t6_done", head_done_valid, 0);
    reset = 1'b0;
    push_head(32'h9000_0009, 5'd0); push_done(5'd0, 6'd1, 1'b0);
    send(32'h9000_0009, 1'b1, 1'b1);
    idle(6);

    check("sb_head_left", exp_head.size(), 0);
    check("sb_done_left", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
